// File: rtl/buffer_window_reader.sv
// Drains a first-word-fall-through buffer into a sliding window of WIN_LEN elements,
// presenting num_windows windows that advance by STRIDE elements each.
module buffer_window_reader #(
    parameter int WIDTH    = 8,
    parameter int PAR_READ = 1,
    parameter int WIN_LEN  = 3,
    parameter int STRIDE   = 1,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CNT_W-1:0]           num_windows,
    input  logic                       buf_valid,
    input  logic [0:WIDTH*PAR_READ-1]  buf_dout,
    output logic                       buf_read_en,
    output logic [0:WIDTH*WIN_LEN-1]   win_data,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int NEED_W = $clog2(WIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                     state_r, state_s;
    logic [NEED_W-1:0]          need_r, need_s;
    logic [NEED_W-1:0]          fill_pos_s;
    logic [CNT_W-1:0]           left_r, left_s;
    logic [0:WIDTH*WIN_LEN-1]   win_r, win_s;
    logic                       pop_s;

    // A pop is gated by reset directly so nothing leaves the buffer while rst is held.
    assign pop_s      = !rst && (state_r == FILL) && buf_valid && (need_r != {NEED_W{1'b0}});
    assign fill_pos_s = NEED_W'(WIN_LEN) - need_r;

    // State, counters and window register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            need_r  <= {NEED_W{1'b0}};
            left_r  <= {CNT_W{1'b0}};
            win_r   <= {(WIDTH*WIN_LEN){1'b0}};
        end else begin
            state_r <= state_s;
            need_r  <= need_s;
            left_r  <= left_s;
            win_r   <= win_s;
        end
    end

    // Next-state, counter and window update logic.
    always_comb begin
        state_s = state_r;
        need_s  = need_r;
        left_s  = left_r;
        win_s   = win_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    left_s  = num_windows;
                    need_s  = NEED_W'(WIN_LEN);
                    state_s = (num_windows == {CNT_W{1'b0}}) ? DONE : FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (pop_s) begin
                    // New elements land right after the ones already held.
                    for (int j = 0; j < PAR_READ; j++) begin
                        win_s[(int'(fill_pos_s) + j)*WIDTH +: WIDTH] = buf_dout[j*WIDTH +: WIDTH];
                    end
                    need_s  = need_r - NEED_W'(PAR_READ);
                    state_s = (need_r == NEED_W'(PAR_READ)) ? PRESENT : FILL;
                end else if (need_r == {NEED_W{1'b0}}) begin
                    state_s = PRESENT;
                end else begin
                    state_s = FILL;
                end
            end
            PRESENT: begin
                if (win_ready) begin
                    if (left_r > CNT_W'(1)) begin
                        left_s = left_r - CNT_W'(1);
                        for (int i = 0; i < WIN_LEN; i++) begin
                            if (i + STRIDE < WIN_LEN) begin
                                win_s[i*WIDTH +: WIDTH] = win_r[((i + STRIDE) % WIN_LEN)*WIDTH +: WIDTH];
                            end else begin
                                win_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
                            end
                        end
                        need_s  = NEED_W'(STRIDE);
                        state_s = FILL;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = PRESENT;
                end
            end
            DONE: begin
                state_s = IDLE;
                need_s  = {NEED_W{1'b0}};
                left_s  = {CNT_W{1'b0}};
                win_s   = {(WIDTH*WIN_LEN){1'b0}};
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign buf_read_en = pop_s;
    assign win_data    = win_r;
    assign win_valid   = (state_r == PRESENT);
    assign busy        = (state_r == FILL) || (state_r == PRESENT);
    assign done        = (state_r == DONE);

endmodule

// File: tb/tb_buffer_window_reader.sv
// Directed bench: two configurations (1/3/1 and 2/4/2) fed by small buffer models
// whose contents are the element sequence 1,2,3,...
module tb_buffer_window_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- configuration A: WIDTH 8, PAR_READ 1, WIN_LEN 3, STRIDE 1
    logic        start_a = 1'b0;
    logic [7:0]  num_windows_a = 8'd0;
    logic        buf_valid_a;
    logic [0:7]  buf_dout_a;
    logic        buf_read_en_a;
    logic [0:23] win_data_a;
    logic        win_valid_a;
    logic        win_ready_a = 1'b1;
    logic        busy_a, done_a;
    logic        src_en_a = 1'b1;
    int          pops_a = 0;
    int          base_a = 0;
    int          ptr_a;

    assign ptr_a       = pops_a - base_a;
    assign buf_valid_a = src_en_a && (ptr_a < 5);
    assign buf_dout_a  = buf_valid_a ? 8'(ptr_a + 1) : 8'h00;
    always @(posedge clk) if (buf_read_en_a === 1'b1) pops_a <= pops_a + 1;

    buffer_window_reader dut_a (
        .clk(clk), .rst(rst), .start(start_a), .num_windows(num_windows_a),
        .buf_valid(buf_valid_a), .buf_dout(buf_dout_a), .buf_read_en(buf_read_en_a),
        .win_data(win_data_a), .win_valid(win_valid_a), .win_ready(win_ready_a),
        .busy(busy_a), .done(done_a)
    );

    // ---------------- configuration B: WIDTH 8, PAR_READ 2, WIN_LEN 4, STRIDE 2
    logic        start_b = 1'b0;
    logic [7:0]  num_windows_b = 8'd0;
    logic        buf_valid_b;
    logic [0:15] buf_dout_b;
    logic        buf_read_en_b;
    logic [0:31] win_data_b;
    logic        win_valid_b;
    logic        win_ready_b = 1'b1;
    logic        busy_b, done_b;
    int          pops_b = 0;

    assign buf_valid_b = (pops_b < 3);
    assign buf_dout_b  = buf_valid_b ? {8'(2*pops_b + 1), 8'(2*pops_b + 2)} : 16'h0000;
    always @(posedge clk) if (buf_read_en_b === 1'b1) pops_b <= pops_b + 1;

    buffer_window_reader #(.WIDTH(8), .PAR_READ(2), .WIN_LEN(4), .STRIDE(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .num_windows(num_windows_b),
        .buf_valid(buf_valid_b), .buf_dout(buf_dout_b), .buf_read_en(buf_read_en_b),
        .win_data(win_data_b), .win_valid(win_valid_b), .win_ready(win_ready_b),
        .busy(busy_b), .done(done_b)
    );

    logic [31:0] win_cap [8];
    int          n_cap;
    int          n_done;

    // Run one job on A; optionally stall the buffer at gate_ptr pops, or hold win_ready low.
    task automatic run_a(input logic [7:0] nw, input int gate_ptr, input bit hold);
        bit          gated = 1'b0;
        bit          held  = 1'b0;
        logic [23:0] snap;
        n_cap = 0;
        n_done = 0;
        base_a = pops_a;
        win_ready_a = !hold;
        @(negedge clk);
        num_windows_a = nw;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int cyc = 0; cyc < 200 && n_done == 0; cyc++) begin
            if (gate_ptr >= 0 && !gated && ptr_a == gate_ptr) begin
                gated = 1'b1;
                src_en_a = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_rd_en", 64'(buf_read_en_a), 64'd0);
                    check("stall_busy", 64'(busy_a), 64'd1);
                    check("stall_valid", 64'(win_valid_a), 64'd0);
                end
                src_en_a = 1'b1;
            end
            if (hold && !held && win_valid_a) begin
                held = 1'b1;
                snap = win_data_a;
                repeat (5) begin
                    check("hold_valid", 64'(win_valid_a), 64'd1);
                    check("hold_data", 64'(win_data_a), 64'(snap));
                    check("hold_rd_en", 64'(buf_read_en_a), 64'd0);
                    @(negedge clk);
                end
                win_ready_a = 1'b1;
            end
            if (win_valid_a && win_ready_a && n_cap < 8) begin
                win_cap[n_cap] = 32'(win_data_a);
                n_cap++;
            end
            if (done_a) n_done++;
            if (n_done == 0) @(negedge clk);
        end
        check("done_seen", 64'(n_done), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done_a), 64'd0);
        check("idle_busy", 64'(busy_a), 64'd0);
        check("idle_win_clear", 64'(win_data_a), 64'd0);
    endtask

    task automatic check_three_windows(input string tag);
        check({tag, "_count"}, 64'(n_cap), 64'd3);
        check({tag, "_w0"}, 64'(win_cap[0]), 64'h010203);
        check({tag, "_w1"}, 64'(win_cap[1]), 64'h020304);
        check({tag, "_w2"}, 64'(win_cap[2]), 64'h030405);
        check({tag, "_pops"}, 64'(ptr_a), 64'd5);
    endtask

    initial begin
        int seen;
        bit found;
        repeat (2) @(negedge clk);
        check("rst_rd_en", 64'(buf_read_en_a), 64'd0);
        check("rst_valid", 64'(win_valid_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_win", 64'(win_data_a), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 3-window job.
        run_a(8'd3, -1, 1'b0);
        check_three_windows("basic");

        // Consumer holds off for 5 cycles on the first window.
        run_a(8'd3, -1, 1'b1);
        check_three_windows("hold");

        // Buffer runs dry for 4 cycles after two pops.
        run_a(8'd3, 2, 1'b0);
        check_three_windows("stall");

        // Zero windows: straight to DONE, no pops.
        run_a(8'd0, -1, 1'b0);
        check("zero_windows", 64'(n_cap), 64'd0);
        check("zero_pops", 64'(ptr_a), 64'd0);

        // Reset during the second window's fill.
        base_a = pops_a;
        win_ready_a = 1'b1;
        num_windows_a = 8'd3;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            if (win_valid_a) found = 1'b1;
            else @(negedge clk);
        end
        check("rstjob_first_window", 64'(found), 64'd1);
        @(negedge clk);
        src_en_a = 1'b0;
        @(negedge clk);
        check("rstjob_in_fill", 64'(busy_a), 64'd1);
        rst = 1'b1;
        src_en_a = 1'b1;
        #1;
        check("rstjob_rd_en_comb", 64'(buf_read_en_a), 64'd0);
        @(negedge clk);
        check("rstjob_busy", 64'(busy_a), 64'd0);
        check("rstjob_valid", 64'(win_valid_a), 64'd0);
        check("rstjob_done", 64'(done_a), 64'd0);
        check("rstjob_win", 64'(win_data_a), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstjob_no_pops", 64'(ptr_a), 64'd3);
        check("rstjob_idle_rd_en", 64'(buf_read_en_a), 64'd0);
        run_a(8'd3, -1, 1'b0);
        check_three_windows("after_rst");

        // Configuration B: two 4-element windows with stride 2.
        n_cap = 0;
        n_done = 0;
        num_windows_b = 8'd2;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 100 && n_done == 0; cyc++) begin
            if (win_valid_b && win_ready_b && n_cap < 8) begin
                win_cap[n_cap] = win_data_b;
                n_cap++;
            end
            if (done_b) n_done++;
            if (n_done == 0) @(negedge clk);
        end
        check("b_done", 64'(n_done), 64'd1);
        check("b_count", 64'(n_cap), 64'd2);
        check("b_w0", 64'(win_cap[0]), 64'h01020304);
        check("b_w1", 64'(win_cap[1]), 64'h03040506);
        check("b_pops", 64'(pops_b), 64'd3);
        @(negedge clk);
        check("b_idle_busy", 64'(busy_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_window_reader.md
BUFFER_WINDOW_READER -- requirements
Module: buffer_window_reader

Interface
REQ-001 Parameter WIDTH, default 8, bits per element.
REQ-002 Parameter PAR_READ, default 1, elements delivered per buffer read; SHALL equal the PAR_READ of the buffer being drained.
REQ-003 Parameter WIN_LEN, default 3, elements per output window; SHALL be a multiple of PAR_READ.
REQ-004 Parameter STRIDE, default 1, elements discarded between consecutive windows; SHALL be a multiple of PAR_READ, 1 <= STRIDE <= WIN_LEN.
REQ-005 Parameter CNT_W, default 8, width of the window counter.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse that begins a job.
REQ-009 num_windows  input  CNT_W  windows to produce; sampled on an accepted start.
REQ-010 buf_valid  input  1  buffer holds at least PAR_READ elements; buf_dout is valid.
REQ-011 buf_dout  input  [0:WIDTH*PAR_READ-1]  buffer head data (first-word-fall-through); bits [0:WIDTH-1] hold the oldest element.
REQ-012 buf_read_en  output  1  pops PAR_READ elements at this clock edge.
REQ-013 win_data  output  [0:WIDTH*WIN_LEN-1]  window; bits [0:WIDTH-1] hold the oldest element.
REQ-014 win_valid  output  1  win_data is valid.
REQ-015 win_ready  input  1  consumer accepts win_data.
REQ-016 busy  output  1  a job is in progress.
REQ-017 done  output  1  one-cycle pulse when the last window is accepted.

Function
REQ-018 The FSM SHALL have four states: IDLE, FILL, PRESENT, DONE.
REQ-019 IDLE: start=1 latches num_windows into windows_left; go to FILL with need=WIN_LEN, or to DONE if num_windows=0.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 FILL: buf_read_en = buf_valid AND need>0.
REQ-022 On each pop, buf_dout SHALL be captured the same edge, appended at the high-index end of the window register, and need SHALL drop by PAR_READ.
REQ-023 FILL: when need reaches 0, the state SHALL go to PRESENT on the next edge; no pop SHALL occur when need=0.
REQ-024 FILL with buf_valid=0 SHALL stall with no state change.
REQ-025 PRESENT: win_valid=1 and win_data SHALL hold stable until win_ready=1; buf_read_en=0.
REQ-026 PRESENT with win_ready=1 and windows_left>1: decrement windows_left; shift the window toward index 0 by STRIDE elements, keeping WIN_LEN-STRIDE elements; set need=STRIDE; go to FILL.
REQ-027 PRESENT with win_ready=1 and windows_left=1: go to DONE.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; the window register SHALL be cleared on entry to IDLE.
REQ-029 busy SHALL be 1 in FILL and PRESENT and 0 in IDLE and DONE.
REQ-030 Window-to-window latency with data already available SHALL be STRIDE/PAR_READ FILL cycles plus one PRESENT cycle minimum.
REQ-031 Counters SHALL not wrap: need ranges 0..WIN_LEN; windows_left ranges 0..2^CNT_W-1.
REQ-032 A job SHALL pop exactly WIN_LEN + (num_windows-1)*STRIDE elements when num_windows>0, and 0 elements otherwise.

Reset
REQ-033 While rst=1, buf_read_en SHALL be 0 combinationally.
REQ-034 On the edge where rst=1: state=IDLE, need=0, windows_left=0, window register=0, win_valid=0, busy=0, done=0.
REQ-035 Reset mid-job SHALL abandon the job without further pops; elements already popped are lost.

Verification
REQ-036 WIDTH=8, PAR_READ=1, WIN_LEN=3, STRIDE=1, num_windows=3, buffer supplies 1,2,3,4,5 -> windows {1,2,3}, {2,3,4}, {3,4,5}; 5 pops; one done pulse.
REQ-037 PAR_READ=2, WIN_LEN=4, STRIDE=2, num_windows=2, words (1,2),(3,4),(5,6) -> windows {1,2,3,4}, {3,4,5,6}; 3 pops.
REQ-038 win_ready held 0 for 5 cycles in PRESENT -> win_data stable, win_valid=1, buf_read_en=0 throughout.
REQ-039 buf_valid deasserted for 4 cycles mid-FILL -> no pop and no state change during those cycles; output matches REQ-036 once buf_valid returns.
REQ-040 num_windows=0 -> IDLE, DONE, IDLE; done pulses once; zero pops; win_valid never asserted.
REQ-041 rst during the second window's FILL -> next cycle IDLE, all outputs 0, no further pops; a new start then reproduces REQ-036.
